// File: rtl/instruction_fetch_unit.sv
// IF stage: PC register, combinational-read instruction memory (instance imem) and the IF/ID register.
// Optional macro IFU_PERF_CNT_EN adds internal fetch/stall/flush counters.

module ifu_imem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  // Contents are preloaded externally; there is deliberately no write port.
  logic [31:0] mem [0:DEPTH-1];

  assign rdata = mem[addr];
endmodule

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        if_valid
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] fetch_word_p0;
  logic [31:0] pc_next_p0;
  logic        advance_p0;

  // Word index wraps modulo IMEM_DEPTH; byte offset bits are ignored.
  ifu_imem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) imem (
    .addr  (pc[AW+1:2]),
    .rdata (fetch_word_p0)
  );

  assign pc_next_p0 = pc + 32'd4;
  assign advance_p0 = !flush && !stall;

  // ---- IF -> IF/ID boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_instr    <= NOP_INSTR;
      if_pc       <= 32'd0;
      if_pc_plus4 <= 32'd4;
      if_valid    <= 1'b0;
    end else if (flush) begin
      pc       <= {redirect_target[31:2], 2'b00};
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (!stall) begin
      if_pc       <= pc;
      if_pc_plus4 <= pc_next_p0;
      if_instr    <= fetch_word_p0;
      if_valid    <= 1'b1;
      pc          <= pc_next_p0;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (advance_p0)      fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && !flush) stall_cnt <= stall_cnt + 32'd1;
      if (flush)           flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  logic unused_advance;
  assign unused_advance = advance_p0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, fetch, stall, flush, flush+stall, wrap, reset priority.
// With IFU_PERF_CNT_EN defined the internal counters are checked as well.

module tb_instruction_fetch_unit;
  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_valid;

  int checks;
  int errors;
  int exp_fetch;
  int exp_stall;
  int exp_flush;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (1024),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .redirect_target (redirect_target),
    .pc              (pc),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instr        (if_instr),
    .if_valid        (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; the edge-type model tracks what the counters should see.
  task automatic step();
    if (rst) begin
      exp_fetch = 0; exp_stall = 0; exp_flush = 0;
    end else if (flush) exp_flush++;
    else if (stall) exp_stall++;
    else exp_fetch++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                          input logic [31:0] e_instr, input logic e_valid);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".if_pc"}, if_pc, e_ifpc);
    chk({tag, ".if_pc_plus4"}, if_pc_plus4, e_ifpc + 32'd4);
    chk({tag, ".if_instr"}, if_instr, e_instr);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, e_valid});
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_fetch = 0; exp_stall = 0; exp_flush = 0;
    for (int i = 0; i < 1024; i++) dut.imem.mem[i] = 32'hA000_0000 | i;
    dut.imem.mem[0] = 32'h0010_0093;
    dut.imem.mem[1] = 32'h0020_0113;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_target = 32'd0;
    repeat (3) step();
    chk_ifid("reset", 32'd0, 32'd0, NOP, 1'b0);
    rst = 1'b0;

    step(); chk_ifid("fetch0", 32'd4, 32'd0, 32'h0010_0093, 1'b1);
    step(); chk_ifid("fetch1", 32'd8, 32'd4, 32'h0020_0113, 1'b1);
    step(); chk_ifid("fetch2", 32'd12, 32'd8, 32'hA000_0002, 1'b1);

    stall = 1'b1;
    step(); chk_ifid("stall1", 32'd12, 32'd8, 32'hA000_0002, 1'b1);
    step(); chk_ifid("stall2", 32'd12, 32'd8, 32'hA000_0002, 1'b1);
    stall = 1'b0;
    step(); chk_ifid("unstall", 32'd16, 32'd12, 32'hA000_0003, 1'b1);
    repeat (4) step();
    chk_ifid("adv32", 32'd32, 32'd28, 32'hA000_0007, 1'b1);

    flush = 1'b1; redirect_target = 32'h28;
    step(); chk_ifid("flush", 32'h28, 32'd28, NOP, 1'b0);
    flush = 1'b0;
    step(); chk_ifid("redir", 32'h2C, 32'h28, 32'hA000_000A, 1'b1);

    flush = 1'b1; stall = 1'b1; redirect_target = 32'h2B;
    step(); chk_ifid("flush_stall", 32'h28, 32'h28, NOP, 1'b0);
    flush = 1'b0; stall = 1'b0;
    step(); chk_ifid("fs_redir", 32'h2C, 32'h28, 32'hA000_000A, 1'b1);

    flush = 1'b1; redirect_target = 32'h1000;
    step(); chk("wrap1000.pc", pc, 32'h1000);
    flush = 1'b0;
    step(); chk_ifid("wrap1000", 32'h1004, 32'h1000, 32'h0010_0093, 1'b1);

    flush = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step(); chk("wraptop.pc", pc, 32'hFFFF_FFFC);
    flush = 1'b0;
    step(); chk_ifid("wraptop", 32'd0, 32'hFFFF_FFFC, 32'hA000_03FF, 1'b1);
    chk("wraptop.plus4_zero", if_pc_plus4, 32'd0);

`ifdef IFU_PERF_CNT_EN
    chk("cnt.fetch", dut.fetch_cnt, exp_fetch);
    chk("cnt.stall", dut.stall_cnt, exp_stall);
    chk("cnt.flush", dut.flush_cnt, exp_flush);
    chk("cnt.fetch_abs", dut.fetch_cnt, 32'd12);
`endif

    stall = 1'b1; rst = 1'b1;
    step(); chk_ifid("rst_stall", 32'd0, 32'd0, NOP, 1'b0);
    stall = 1'b0; rst = 1'b0;
    step(); step();
    flush = 1'b1; rst = 1'b1; redirect_target = 32'h100;
    step(); chk_ifid("rst_flush", 32'd0, 32'd0, NOP, 1'b0);
`ifdef IFU_PERF_CNT_EN
    chk("cnt.fetch_rst", dut.fetch_cnt, 32'd0);
    chk("cnt.stall_rst", dut.stall_cnt, 32'd0);
    chk("cnt.flush_rst", dut.flush_cnt, 32'd0);
`endif
    flush = 1'b0; rst = 1'b0;
    step(); chk_ifid("post_rst", 32'd4, 32'd0, 32'h0010_0093, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
